// File: rtl/sn_tile_scheduler_if.sv
// sn_tile_scheduler_if
// Bundles the job, operand-buffer, SNG, result and status signals of the
// tile scheduler. Signal names keep their i_/o_ prefixes as seen from the
// scheduler itself.
//   master : the scheduler (drives every o_* signal)
//   slave  : the surrounding layer controller / SNG bank / writeback side
interface sn_tile_scheduler_if #(
    parameter int NUM_BIT = 8,
    parameter int TILE_W  = 8
);
    // job interface
    logic               i_job_valid;
    logic               o_job_ready;
    logic [TILE_W-1:0]  i_job_ntiles;
    // operand buffer
    logic               o_load;
    logic               i_load_done;
    logic [TILE_W-1:0]  o_tile_idx;
    // SNG bank and neuron stream
    logic               o_start_gen;
    logic               o_stop_gen;
    logic               i_isgen;
    logic               i_sn_bit;
    // result handshake
    logic               o_res_valid;
    logic               i_res_ready;
    logic [NUM_BIT:0]   o_res_count;
    logic [TILE_W-1:0]  o_res_tile;
    // control / status
    logic               i_abort;
    logic               o_busy;
    logic               o_job_done;
    logic               o_err;

    modport master (
        input  i_job_valid, i_job_ntiles, i_load_done, i_isgen, i_sn_bit,
               i_res_ready, i_abort,
        output o_job_ready, o_load, o_tile_idx, o_start_gen, o_stop_gen,
               o_res_valid, o_res_count, o_res_tile, o_busy, o_job_done, o_err
    );

    modport slave (
        output i_job_valid, i_job_ntiles, i_load_done, i_isgen, i_sn_bit,
               i_res_ready, i_abort,
        input  o_job_ready, o_load, o_tile_idx, o_start_gen, o_stop_gen,
               o_res_valid, o_res_count, o_res_tile, o_busy, o_job_done, o_err
    );
endinterface

// File: rtl/sn_tile_scheduler.sv
// sn_tile_scheduler
// Walks the SNG bank through a multi-tile job: per tile it loads the operand
// buffer, starts the SNG, counts ones on the neuron output stream and hands
// the count to writeback over valid/ready.
// Ports:
//   i_clk_sched : clock
//   i_rst_sched : synchronous, active-low reset
//   bus         : sn_tile_scheduler_if.master (job, load, SNG, result, status)
// Every output is a register; o_load, o_start_gen, o_stop_gen and o_job_done
// are one-cycle pulses raised on the edge that enters the related state.
module sn_tile_scheduler #(
    parameter int NUM_BIT    = 8,
    parameter int TILE_W     = 8,
    parameter int STREAM_LEN = 255,
    parameter int START_TO   = 15
) (
    input  logic               i_clk_sched,
    input  logic               i_rst_sched,
    sn_tile_scheduler_if.master bus
);
    localparam int CNT_W = NUM_BIT + 1;
    localparam int TO_W  = (START_TO > 1) ? $clog2(START_TO + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAITG, S_RUN, S_OUT, S_DONE
    } state_t;

    state_t             state_reg;
    logic [TILE_W-1:0]  ntiles_reg;
    logic [TILE_W-1:0]  tile_idx_reg;
    logic [CNT_W-1:0]   ones_cnt_reg;
    logic [CNT_W-1:0]   cyc_cnt_reg;
    logic [TO_W-1:0]    to_cnt_reg;
    logic               job_ready_reg;
    logic               load_reg;
    logic               start_gen_reg;
    logic               stop_gen_reg;
    logic               res_valid_reg;
    logic               busy_reg;
    logic               job_done_reg;
    logic               err_reg;

    always_ff @(posedge i_clk_sched) begin
        if (!i_rst_sched) begin
            state_reg     <= S_IDLE;
            ntiles_reg    <= '0;
            tile_idx_reg  <= '0;
            ones_cnt_reg  <= '0;
            cyc_cnt_reg   <= '0;
            to_cnt_reg    <= '0;
            job_ready_reg <= 1'b1;
            load_reg      <= 1'b0;
            start_gen_reg <= 1'b0;
            stop_gen_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            job_done_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            load_reg      <= 1'b0;
            start_gen_reg <= 1'b0;
            stop_gen_reg  <= 1'b0;
            job_done_reg  <= 1'b0;

            // DONE already exits next cycle, so an abort there would only
            // stretch the o_job_done pulse.
            if (bus.i_abort && state_reg != S_IDLE && state_reg != S_DONE) begin
                if (state_reg == S_WAITG || state_reg == S_RUN)
                    stop_gen_reg <= 1'b1;
                res_valid_reg <= 1'b0;
                job_done_reg  <= 1'b1;
                state_reg     <= S_DONE;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (bus.i_job_valid) begin
                            ntiles_reg    <= (bus.i_job_ntiles == '0) ? TILE_W'(1) : bus.i_job_ntiles;
                            tile_idx_reg  <= '0;
                            err_reg       <= 1'b0;
                            job_ready_reg <= 1'b0;
                            busy_reg      <= 1'b1;
                            load_reg      <= 1'b1;
                            state_reg     <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (bus.i_load_done) begin
                            start_gen_reg <= 1'b1;
                            state_reg     <= S_START;
                        end
                    end
                    S_START: begin
                        ones_cnt_reg <= '0;
                        cyc_cnt_reg  <= '0;
                        to_cnt_reg   <= '0;
                        state_reg    <= S_WAITG;
                    end
                    // WAITG and RUN share the counting path: the first
                    // streaming cycle seen in WAITG is already counted, which
                    // also covers STREAM_LEN == 1.
                    S_WAITG, S_RUN: begin
                        if (bus.i_isgen) begin
                            cyc_cnt_reg  <= cyc_cnt_reg + CNT_W'(1);
                            ones_cnt_reg <= ones_cnt_reg + CNT_W'(bus.i_sn_bit);
                            if (cyc_cnt_reg + CNT_W'(1) == CNT_W'(STREAM_LEN)) begin
                                stop_gen_reg  <= 1'b1;
                                res_valid_reg <= 1'b1;
                                state_reg     <= S_OUT;
                            end else begin
                                state_reg <= S_RUN;
                            end
                        end else if (state_reg == S_RUN) begin
                            // SNG ended the stream on its own: no stop needed.
                            res_valid_reg <= 1'b1;
                            state_reg     <= S_OUT;
                        end else if (to_cnt_reg + TO_W'(1) == TO_W'(START_TO)) begin
                            err_reg      <= 1'b1;
                            stop_gen_reg <= 1'b1;
                            job_done_reg <= 1'b1;
                            state_reg    <= S_DONE;
                        end else begin
                            to_cnt_reg <= to_cnt_reg + TO_W'(1);
                        end
                    end
                    S_OUT: begin
                        if (bus.i_res_ready) begin
                            res_valid_reg <= 1'b0;
                            if (tile_idx_reg == ntiles_reg - TILE_W'(1)) begin
                                job_done_reg <= 1'b1;
                                state_reg    <= S_DONE;
                            end else begin
                                tile_idx_reg <= tile_idx_reg + TILE_W'(1);
                                load_reg     <= 1'b1;
                                state_reg    <= S_LOAD;
                            end
                        end
                    end
                    S_DONE: begin
                        job_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.o_job_ready = job_ready_reg;
    assign bus.o_load      = load_reg;
    assign bus.o_tile_idx  = tile_idx_reg;
    assign bus.o_start_gen = start_gen_reg;
    assign bus.o_stop_gen  = stop_gen_reg;
    assign bus.o_res_valid = res_valid_reg;
    assign bus.o_res_count = ones_cnt_reg;
    assign bus.o_res_tile  = tile_idx_reg;
    assign bus.o_busy      = busy_reg;
    assign bus.o_job_done  = job_done_reg;
    assign bus.o_err       = err_reg;
endmodule

// File: tb/tb_sn_tile_scheduler.sv
// tb_sn_tile_scheduler
// Directed and random jobs for sn_tile_scheduler. The bench plays the
// operand buffer, the SNG bank and the writeback consumer; expected result
// counts are the number of ones it drove in the first STREAM_LEN streaming
// cycles of each tile.
module tb_sn_tile_scheduler;
    localparam int NUM_BIT    = 8;
    localparam int TILE_W     = 8;
    localparam int STREAM_LEN = 255;
    localparam int START_TO   = 15;

    logic i_clk_sched = 1'b0;
    logic i_rst_sched = 1'b0;
    always #5 i_clk_sched = ~i_clk_sched;

    sn_tile_scheduler_if #(.NUM_BIT(NUM_BIT), .TILE_W(TILE_W)) bus ();

    sn_tile_scheduler #(
        .NUM_BIT(NUM_BIT), .TILE_W(TILE_W),
        .STREAM_LEN(STREAM_LEN), .START_TO(START_TO)
    ) dut (
        .i_clk_sched(i_clk_sched),
        .i_rst_sched(i_rst_sched),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // environment configuration
    int sng_delay = 2;
    bit sng_en    = 1'b1;
    int drop_len  = -1;
    int bit_mode  = 0;
    int abort_at  = -1;
    int rst_at    = -1;
    int stall_cfg = 0;

    // environment / model state
    bit ld_pending = 1'b0;
    int ld_timer   = 0;
    bit sng_pending = 1'b0;
    int sng_wait   = 0;
    bit sng_active = 1'b0;
    int k          = 0;
    int tally      = 0;
    int exp_tile   = 0;
    int stall      = 0;
    bit prev_valid = 1'b0;
    bit abort_chk  = 1'b0;
    bit rst_hit    = 1'b0;
    int n_load = 0, n_start = 0, n_stop = 0, n_done = 0, n_results = 0;
    int last_count = -1, last_tile = -1;
    int cyc = 0, start_cyc = 0, stop_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_job_ready"}, bus.o_job_ready, 1);
        check({tag, "_load"},      bus.o_load, 0);
        check({tag, "_tile_idx"},  bus.o_tile_idx, 0);
        check({tag, "_start_gen"}, bus.o_start_gen, 0);
        check({tag, "_stop_gen"},  bus.o_stop_gen, 0);
        check({tag, "_res_valid"}, bus.o_res_valid, 0);
        check({tag, "_res_count"}, bus.o_res_count, 0);
        check({tag, "_res_tile"},  bus.o_res_tile, 0);
        check({tag, "_busy"},      bus.o_busy, 0);
        check({tag, "_job_done"},  bus.o_job_done, 0);
        check({tag, "_err"},       bus.o_err, 0);
    endtask

    // One clock: sample outputs 1 time unit after the edge, then drive the
    // inputs the next edge will see.
    task automatic tick();
        bit b;
        @(posedge i_clk_sched);
        #1;
        cyc++;
        if (abort_chk) begin
            check("abort_stop_gen", bus.o_stop_gen, 1);
            check("abort_job_done", bus.o_job_done, 1);
            check("abort_res_valid", bus.o_res_valid, 0);
            abort_chk = 1'b0;
        end
        bus.i_abort = 1'b0;
        if (bus.o_load)      n_load++;
        if (bus.o_start_gen) begin n_start++; start_cyc = cyc; end
        if (bus.o_stop_gen)  begin n_stop++;  stop_cyc  = cyc; end
        if (bus.o_job_done)  n_done++;

        // operand buffer: answers a load after 1..4 cycles
        bus.i_load_done = 1'b0;
        if (ld_pending) begin
            if (ld_timer == 0) begin
                bus.i_load_done = 1'b1;
                ld_pending = 1'b0;
            end else begin
                ld_timer--;
            end
        end
        if (bus.o_load) begin
            ld_pending = 1'b1;
            ld_timer = $urandom_range(0, 3);
        end

        // SNG bank: streams sng_delay cycles after the start pulse until
        // stopped, or until drop_len cycles if it ends the stream itself
        bus.i_isgen  = 1'b0;
        bus.i_sn_bit = 1'($urandom_range(0, 1));
        if (bus.o_stop_gen) sng_active = 1'b0;
        if (sng_pending) begin
            sng_wait--;
            if (sng_wait == 0) begin
                sng_pending = 1'b0;
                sng_active = 1'b1;
                k = 0;
            end
        end
        if (bus.o_start_gen && sng_en) begin
            sng_pending = 1'b1;
            sng_wait = sng_delay;
        end
        if (sng_active && rst_at >= 0 && k == rst_at) begin
            i_rst_sched = 1'b0;
            rst_hit = 1'b1;
            rst_at = -1;
            sng_active = 1'b0;
        end
        if (sng_active) begin
            if (k == drop_len) begin
                sng_active = 1'b0;
            end else begin
                if (abort_at >= 0 && k == abort_at) begin
                    bus.i_abort = 1'b1;
                    abort_chk = 1'b1;
                    abort_at = -1;
                end
                case (bit_mode)
                    0:       b = (k % 2 == 0);
                    1:       b = 1'b1;
                    default: b = 1'($urandom_range(0, 1));
                endcase
                bus.i_isgen  = 1'b1;
                bus.i_sn_bit = b;
                if (k < STREAM_LEN) tally += int'(b);
                k++;
            end
        end

        // writeback consumer
        bus.i_res_ready = 1'b0;
        if (bus.o_res_valid) begin
            check("res_count", bus.o_res_count, tally);
            check("res_tile", bus.o_res_tile, exp_tile);
            check("tile_idx", bus.o_tile_idx, exp_tile);
            if (!prev_valid) stall = stall_cfg;
            if (stall == 0) begin
                bus.i_res_ready = 1'b1;
                n_results++;
                last_count = int'(bus.o_res_count);
                last_tile  = int'(bus.o_res_tile);
                exp_tile++;
                tally = 0;
            end else begin
                stall--;
            end
        end
        prev_valid = bus.o_res_valid && !bus.i_res_ready;
    endtask

    task automatic run_job(input int ntiles, input int exp_loads, input int exp_results,
                           input int exp_stops, input bit exp_err);
        int budget;
        n_load = 0; n_start = 0; n_stop = 0; n_done = 0; n_results = 0;
        tally = 0; exp_tile = 0; prev_valid = 1'b0; last_count = -1; last_tile = -1;
        budget = 0;
        while (!bus.o_job_ready && budget < 50) begin tick(); budget++; end
        check("job_ready_before_accept", bus.o_job_ready, 1);
        bus.i_job_valid  = 1'b1;
        bus.i_job_ntiles = TILE_W'(ntiles);
        tick();
        bus.i_job_valid = 1'b0;
        check("accept_load_pulse", bus.o_load, 1);
        check("accept_job_ready", bus.o_job_ready, 0);
        check("accept_busy", bus.o_busy, 1);
        check("accept_err_clear", bus.o_err, 0);
        budget = 0;
        while (n_done == 0 && !rst_hit && budget < 400 * exp_loads + 100) begin
            // job requests while busy must be ignored
            bus.i_job_valid  = 1'($urandom_range(0, 1));
            bus.i_job_ntiles = TILE_W'($urandom_range(0, 5));
            tick();
            budget++;
        end
        bus.i_job_valid = 1'b0;
        if (!rst_hit) begin
            check("job_done_seen", n_done, 1);
            check("n_load", n_load, exp_loads);
            check("n_start_gen", n_start, exp_loads);
            check("n_results", n_results, exp_results);
            check("n_stop_gen", n_stop, exp_stops);
            check("done_err", bus.o_err, exp_err);
            tick();
            check("after_done_job_ready", bus.o_job_ready, 1);
            check("after_done_busy", bus.o_busy, 0);
            check("job_done_single_pulse", bus.o_job_done, 0);
            check("err_sticky", bus.o_err, exp_err);
        end
    endtask

    initial begin
        bus.i_job_valid  = 1'b0;
        bus.i_job_ntiles = '0;
        bus.i_load_done  = 1'b0;
        bus.i_isgen      = 1'b0;
        bus.i_sn_bit     = 1'b0;
        bus.i_res_ready  = 1'b0;
        bus.i_abort      = 1'b0;

        repeat (3) tick();
        check_reset_outputs("reset");
        i_rst_sched = 1'b1;
        tick();
        check_reset_outputs("idle");

        // one tile, alternating bits from the first stream cycle: 128 of 255
        sng_delay = 2; bit_mode = 0; stall_cfg = 0;
        run_job(1, 1, 1, 1, 1'b0);
        check("t1_count", last_count, 128);
        check("t1_tile", last_tile, 0);
        $display("job ntiles=1 alt bits: count=%0d tile=%0d", last_count, last_tile);

        // three tiles, all ones, writeback stalls 5 cycles per result
        bit_mode = 1; stall_cfg = 5;
        run_job(3, 3, 3, 3, 1'b0);
        check("t3_last_count", last_count, 255);
        check("t3_last_tile", last_tile, 2);
        $display("job ntiles=3 all ones stalled: results=%0d last_tile=%0d", n_results, last_tile);

        // ntiles=0 behaves as one tile
        stall_cfg = 0; bit_mode = 2;
        run_job(0, 1, 1, 1, 1'b0);
        check("t0_tile", last_tile, 0);
        $display("job ntiles=0: results=%0d", n_results);

        // SNG never streams: start timeout
        sng_en = 1'b0;
        run_job(1, 1, 0, 1, 1'b1);
        check("timeout_latency", ((stop_cyc - start_cyc) >= START_TO) &&
                                 ((stop_cyc - start_cyc) <= START_TO + 1), 1);
        $display("job timeout: stop %0d cycles after start, err=%0d", stop_cyc - start_cyc, bus.o_err);
        sng_en = 1'b1;

        // SNG ends the stream after 100 cycles of ones; err cleared by accept
        bit_mode = 1; drop_len = 100;
        run_job(1, 1, 1, 0, 1'b0);
        check("drop_count", last_count, 100);
        $display("job early drop: count=%0d", last_count);
        drop_len = -1;

        // abort mid-stream
        abort_at = 50;
        run_job(2, 1, 0, 1, 1'b0);
        $display("job abort in RUN: results=%0d stops=%0d", n_results, n_stop);

        // reset pulse mid-stream abandons the job
        rst_at = 60;
        run_job(1, 1, 1, 1, 1'b0);
        check("reset_hit", rst_hit, 1);
        tick();
        i_rst_sched = 1'b1;
        check_reset_outputs("midrun_reset");
        ld_pending = 1'b0; sng_pending = 1'b0; sng_active = 1'b0;
        prev_valid = 1'b0; rst_hit = 1'b0;
        $display("mid-run reset applied");

        bit_mode = 2; sng_delay = 3;
        run_job(1, 1, 1, 1, 1'b0);
        $display("job after reset: count=%0d", last_count);

        // random jobs
        for (int j = 0; j < 4; j++) begin
            int nt;
            nt = $urandom_range(1, 3);
            sng_delay = $urandom_range(1, 4);
            stall_cfg = $urandom_range(0, 3);
            bit_mode = 2;
            run_job(nt, nt, nt, nt, 1'b0);
            $display("random job %0d ntiles=%0d: results=%0d last_count=%0d", j, nt, n_results, last_count);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
